// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM read streamer.
package ram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int STREAM_BUF_DEPTH = 2;
   localparam int READ_LATENCY     = 1;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry output buffer; head entry drives the stream directly from a register.
module stream_skid_fifo #(
   parameter int Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [1:0]       count_o,
   output logic [Width-1:0] head_o,
   output logic             valid_o
);

   logic [Width-1:0] head_q, head_d;
   logic [Width-1:0] tail_q, tail_d;
   logic [1:0]       count_q, count_d;
   logic             pop_eff;

   // A pop against an empty buffer has nothing to remove and is ignored.
   assign pop_eff = pop_i && (count_q != 2'd0);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      unique case ({push_i, pop_eff})
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d  = data_i;
               count_d = 2'd1;
            end else if (count_q == 2'd1) begin
               tail_d  = data_i;
               count_d = 2'd2;
            end
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               head_d = data_i;
            end else begin
               head_d = tail_q;
               tail_d = data_i;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = head_q;
   assign valid_o = (count_q != 2'd0);

endmodule

// File: rtl/ram_read_streamer.sv
// Walks a RAM address range and streams the words out over valid/ready,
// absorbing the one-cycle registered read latency.
module ram_read_streamer
   import ram_pkg::*;
#(
   parameter int Width = 8,
   parameter int Depth = 16,
   localparam int AW   = $clog2(Depth)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AW-1:0]    startAddr,
   input  logic [AW:0]      len,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    rdAddr,
   input  logic [Width-1:0] rdData,
   output logic             outValid,
   output logic [Width-1:0] outData,
   input  logic             outReady
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(Depth - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   remain_q, remain_d;
   logic [AW:0]   words_q, words_d;
   logic          inflight_q, inflight_d;
   logic          done_q, done_d;

   logic          accept, issue, pop, last_issue, last_pop;
   logic [1:0]    buf_count;
   logic [2:0]    occupancy;

   assign accept     = (state_q == IDLE) && start;
   assign pop        = outValid && outReady;
   assign last_issue = issue && (remain_q == (AW+1)'(1));
   assign last_pop   = pop && (words_q == (AW+1)'(1));

   // Entries committed after this cycle: buffered + arriving - leaving.
   assign occupancy  = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start && (len != '0)) state_d = READ;
         end
         READ: begin
            if (last_issue) state_d = last_pop ? IDLE : DRAIN;
         end
         DRAIN: begin
            if (last_pop) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q != IDLE);
      issue  = (state_q == READ) && (occupancy < 3'(STREAM_BUF_DEPTH));
      done_d = ((state_q != IDLE) && (state_d == IDLE)) || (accept && (len == '0));
   end

   // Address, remaining-issue and remaining-word counters.
   always_comb begin
      addr_d     = addr_q;
      remain_d   = remain_q;
      words_d    = words_q;
      inflight_d = issue;
      if (accept) begin
         addr_d   = startAddr;
         remain_d = len;
         words_d  = len;
      end else begin
         if (issue) begin
            remain_d = remain_q - (AW+1)'(1);
            // The final issue leaves rdAddr parked on the last address read.
            if (!last_issue) addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
         end
         if (pop) words_d = words_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q     <= '0;
         remain_q   <= '0;
         words_q    <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         words_q    <= words_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
      end
   end

   stream_skid_fifo #(
      .Width (Width)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (inflight_q),
      .data_i  (rdData),
      .pop_i   (pop),
      .count_o (buf_count),
      .head_o  (outData),
      .valid_o (outValid)
   );

   assign rdAddr = addr_q;
   assign done   = done_q;

endmodule

// File: tb/tb_ram_read_streamer.sv
// Scoreboard bench for ram_read_streamer against a behavioural registered-read RAM.
module tb_ram_read_streamer;

   localparam int Width = 8;
   localparam int Depth = 16;
   localparam int AW    = $clog2(Depth);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [AW-1:0]    startAddr = '0;
   logic [AW:0]      len = '0;
   logic             busy, done, outValid;
   logic [AW-1:0]    rdAddr;
   logic [Width-1:0] rdData;
   logic [Width-1:0] outData;
   logic             outReady = 1'b1;

   logic [Width-1:0] mem [Depth];
   logic [Width-1:0] exp_q [$];

   int n_checks = 0;
   int n_fail   = 0;
   int rda [8];

   always #5 clk = ~clk;

   always @(posedge clk) rdData <= mem[rdAddr];

   ram_read_streamer #(.Width(Width), .Depth(Depth)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .startAddr (startAddr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .rdAddr    (rdAddr),
      .rdData    (rdData),
      .outValid  (outValid),
      .outData   (outData),
      .outReady  (outReady)
   );

   function automatic logic ready_for(input int mode, input int c);
      logic [7:0] pat;
      pat = 8'b0110_1001;  // bit i = ready in cycle i: 1,0,0,1,0,1,1,0
      if (mode == 0) return 1'b1;
      return pat[c % 8];
   endfunction

   // Runs one transfer; expected words are queued at start and popped on each handshake.
   task automatic run_stream(input int sa, input int ln, input int mode,
                             input int restart_cyc, input int rst_after,
                             output int words, output int done_cyc, output int first_vld);
      logic             prev_stall;
      logic [Width-1:0] prev_data;
      logic             rst_pend, in_rst;
      logic [Width-1:0] e;
      bit               fin;
      words = 0; done_cyc = -1; first_vld = -1;
      prev_stall = 1'b0; prev_data = '0; rst_pend = 1'b0; in_rst = 1'b0; fin = 0;
      exp_q.delete();
      for (int i = 0; i < ln; i++) exp_q.push_back(8'((sa + i) % Depth) + 8'h10);
      for (int i = 0; i < 8; i++) rda[i] = -1;

      @(posedge clk); #1;
      start = 1'b1; startAddr = AW'(sa); len = (AW+1)'(ln); outReady = ready_for(mode, 0);
      for (int c = 1; c < 200 && !fin; c++) begin
         @(posedge clk); #1;
         if (in_rst) begin
            rst = 1'b0;
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || outValid !== 1'b0 || done !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_abandon: busy=%b outValid=%b done=%b, required 0 0 0", busy, outValid, done);
            end
            exp_q.delete();
            fin = 1;
         end else begin
            if (rst_pend) begin
               rst = 1'b1; in_rst = 1'b1;
            end
            start = (c == restart_cyc);
            if (c == restart_cyc) begin
               startAddr = AW'(9); len = (AW+1)'(3);
            end
            outReady = ready_for(mode, c);
            @(negedge clk);
            if (c < 8) rda[c] = int'(rdAddr);
            if (!in_rst) begin
               if (dut.u_fifo.count_o > 2'd2) begin
                  n_checks++; n_fail++;
                  $display("FAIL buf_bound: count=%0d, required <=2", dut.u_fifo.count_o);
               end
               if (prev_stall) begin
                  n_checks++;
                  if (outValid !== 1'b1 || outData !== prev_data) begin
                     n_fail++;
                     $display("FAIL stall_stable c=%0d: valid=%b data=%h, required 1 %h", c, outValid, outData, prev_data);
                  end
               end
               if (outValid === 1'b1 && first_vld < 0) first_vld = c;
               if (outValid === 1'b1 && outReady) begin
                  n_checks++;
                  if (exp_q.size() == 0) begin
                     n_fail++;
                     $display("FAIL extra_word c=%0d: got %h, required no word", c, outData);
                  end else begin
                     e = exp_q.pop_front();
                     if (outData !== e) begin
                        n_fail++;
                        $display("FAIL word%0d c=%0d: got %h, required %h", words, c, outData, e);
                     end
                  end
                  words++;
                  if (rst_after > 0 && words == rst_after) rst_pend = 1'b1;
               end
               prev_stall = (outValid === 1'b1) && !outReady;
               prev_data  = outData;
               if (done === 1'b1) begin
                  done_cyc = c;
                  n_checks++;
                  if (busy !== 1'b0) begin
                     n_fail++;
                     $display("FAIL busy_at_done c=%0d: busy=%b, required 0", c, busy);
                  end
                  fin = 1;
               end else if (ln > 0 && busy !== 1'b1) begin
                  n_checks++; n_fail++;
                  $display("FAIL busy_high c=%0d: busy=%b, required 1", c, busy);
               end
            end
         end
      end
      start = 1'b0;
      if (!fin) begin
         n_checks++; n_fail++;
         $display("FAIL timeout: no done within budget, required done pulse");
      end
      if (rst_after == 0 && done_cyc >= 0) begin
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: done=%b one cycle after pulse, required 0", done);
         end
         n_checks++;
         if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_words: %0d left unread, required 0", exp_q.size());
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || outValid !== 1'b0 || outData !== 8'h00 || rdAddr !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b vld=%b data=%h addr=%h, required all 0",
                  busy, done, outValid, outData, rdAddr);
      end
   endtask

   task automatic test_basic();
      int w, d, f;
      run_stream(2, 4, 0, -1, 0, w, d, f);
      n_checks++;
      if (f != 3) begin
         n_fail++; $display("FAIL basic_first_valid: cycle %0d, required 3", f);
      end
      n_checks++;
      if (d != 7) begin
         n_fail++; $display("FAIL basic_done_cycle: cycle %0d, required 7", d);
      end
      n_checks++;
      if (w != 4) begin
         n_fail++; $display("FAIL basic_words: %0d, required 4", w);
      end
   endtask

   task automatic test_wrap();
      int w, d, f;
      int exp_a [4];
      exp_a = '{14, 15, 0, 1};
      run_stream(14, 4, 0, -1, 0, w, d, f);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rda[i+1] != exp_a[i]) begin
            n_fail++; $display("FAIL wrap_rdaddr c=%0d: %0d, required %0d", i + 1, rda[i+1], exp_a[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int w, d, f;
      run_stream(3, 8, 1, -1, 0, w, d, f);
      n_checks++;
      if (w != 8) begin
         n_fail++; $display("FAIL bp_words: %0d, required 8", w);
      end
   endtask

   task automatic test_len_zero();
      int w, d, f;
      run_stream(5, 0, 0, -1, 0, w, d, f);
      n_checks++;
      if (d != 1) begin
         n_fail++; $display("FAIL len0_done_cycle: cycle %0d, required 1", d);
      end
      n_checks++;
      if (f != -1 || w != 0) begin
         n_fail++; $display("FAIL len0_output: first valid %0d words %0d, required none", f, w);
      end
   endtask

   task automatic test_reset_mid();
      int w, d, f;
      run_stream(0, 6, 0, -1, 2, w, d, f);
      n_checks++;
      if (d != -1) begin
         n_fail++; $display("FAIL reset_mid_done: done seen at cycle %0d, required none", d);
      end
      run_stream(0, 2, 0, -1, 0, w, d, f);
      n_checks++;
      if (w != 2 || d != 5) begin
         n_fail++; $display("FAIL after_reset_xfer: words %0d done %0d, required 2 and 5", w, d);
      end
   endtask

   task automatic test_restart_ignored();
      int w, d, f;
      run_stream(1, 5, 0, 3, 0, w, d, f);
      n_checks++;
      if (w != 5 || d != 8) begin
         n_fail++; $display("FAIL restart_ignored: words %0d done %0d, required 5 and 8", w, d);
      end
   endtask

   task automatic test_full_sweep();
      int w, d, f;
      run_stream(5, 16, 0, -1, 0, w, d, f);
      n_checks++;
      if (w != 16 || d != 19) begin
         n_fail++; $display("FAIL full_sweep: words %0d done %0d, required 16 and 19", w, d);
      end
   endtask

   initial begin
      for (int i = 0; i < Depth; i++) mem[i] = 8'(i) + 8'h10;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_len_zero();
      test_reset_mid();
      test_restart_ignored();
      test_full_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
